// File: rtl/cache_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_pkg
// Brief    : Shared widths, responder state encoding and log2 helper for the
//            cache memory port.
// Revision : 1.0 - initial release
// ============================================================================
package cache_mem_pkg;

  localparam int ADDR_W   = 32;
  localparam int BLOCK_W  = 128;
  localparam int OFFSET_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_responder_if
// Brief    : Block-level memory request bus between cache and responder.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_mem_responder_if #(
  parameter int ADDR_W  = cache_mem_pkg::ADDR_W,
  parameter int BLOCK_W = cache_mem_pkg::BLOCK_W
) ();

  logic [ADDR_W-1:0]  mem_req_addr;
  logic [BLOCK_W-1:0] mem_req_dataout;
  logic               mem_req_rw;
  logic               mem_req_valid;
  logic [BLOCK_W-1:0] mem_req_datain;
  logic               mem_req_ready;

  modport master (
    output mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid,
    input  mem_req_datain, mem_req_ready
  );

  modport slave (
    input  mem_req_addr, mem_req_dataout, mem_req_rw, mem_req_valid,
    output mem_req_datain, mem_req_ready
  );

endinterface
`default_nettype wire

// File: rtl/mem_block_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_block_array
// Brief    : DEPTH x BLOCK_W block store, one synchronous port, entries
//            initialised to their own index on reset.
// Revision : 1.0 - initial release
// ============================================================================
module mem_block_array #(
  parameter int DEPTH   = 64,
  parameter int BLOCK_W = cache_mem_pkg::BLOCK_W
) (
  input  wire logic                                     clk,
  input  wire logic                                     rst,
  input  wire logic                                     we,
  input  wire logic                                     re,
  input  wire logic [cache_mem_pkg::clog2(DEPTH)-1:0]   idx,
  input  wire logic [BLOCK_W-1:0]                       wdata,
  output logic      [BLOCK_W-1:0]                       rdata
);

  logic [BLOCK_W-1:0] r_mem [DEPTH];
  logic [BLOCK_W-1:0] r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= BLOCK_W'(i);
      end
      r_rdata <= '0;
    end else begin
      if (we) r_mem[idx] <= wdata;
      if (re) r_rdata <= r_mem[idx];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_responder
// Brief    : Fixed-latency main-memory model answering the cache's mem_req_*
//            block port; one outstanding read or write at a time.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_responder #(
  parameter int ADDR_W   = cache_mem_pkg::ADDR_W,
  parameter int BLOCK_W  = cache_mem_pkg::BLOCK_W,
  parameter int DEPTH    = 64,
  parameter int OFFSET_W = cache_mem_pkg::OFFSET_W,
  parameter int LATENCY  = 2,
  parameter int CNT_W    = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  cache_mem_responder_if.slave   mem,
  output logic [CNT_W-1:0]       rd_count,
  output logic [CNT_W-1:0]       wr_count
);

  import cache_mem_pkg::*;

  localparam int c_idx_w = clog2(DEPTH);
  localparam int c_lat_w = (LATENCY > 1) ? clog2(LATENCY) : 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_lat_w-1:0]   r_lat_cnt;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_rw;
  logic [BLOCK_W-1:0]   r_wdata;
  logic [CNT_W-1:0]     r_rd_count;
  logic [CNT_W-1:0]     r_wr_count;
  logic                 w_accept;
  logic                 w_finish;
  logic                 w_we;
  logic                 w_re;
  logic                 w_addr_unused;

  // Only the block-index slice matters; the rest aliases.
  assign w_addr_unused = ^{mem.mem_req_addr[ADDR_W-1:OFFSET_W+c_idx_w],
                           mem.mem_req_addr[OFFSET_W-1:0]};

  always_comb begin
    w_state_nxt       = r_state;
    w_accept          = 1'b0;
    w_finish          = 1'b0;
    mem.mem_req_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        mem.mem_req_ready = 1'b1;
        if (mem.mem_req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_lat_cnt == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        mem.mem_req_ready = 1'b1;
        w_state_nxt       = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The array access lands on the same edge that enters DONE.
  assign w_we = w_finish &  r_rw;
  assign w_re = w_finish & ~r_rw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lat_cnt  <= '0;
      r_idx      <= '0;
      r_rw       <= 1'b0;
      r_wdata    <= '0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx     <= mem.mem_req_addr[OFFSET_W +: c_idx_w];
        r_rw      <= mem.mem_req_rw;
        r_wdata   <= mem.mem_req_dataout;
        r_lat_cnt <= c_lat_w'(LATENCY - 1);
      end else if (r_state == ST_BUSY && r_lat_cnt != '0) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end
      if (w_re && r_rd_count != {CNT_W{1'b1}}) r_rd_count <= r_rd_count + 1'b1;
      if (w_we && r_wr_count != {CNT_W{1'b1}}) r_wr_count <= r_wr_count + 1'b1;
    end
  end

  mem_block_array #(
    .DEPTH   (DEPTH),
    .BLOCK_W (BLOCK_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .re    (w_re),
    .idx   (r_idx),
    .wdata (r_wdata),
    .rdata (mem.mem_req_datain)
  );

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_mem_responder
// Brief    : Scoreboard bench for cache_mem_responder against a block-array
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_responder;

  import cache_mem_pkg::*;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [BLOCK_W-1:0] data;
    int                 rd;
    int                 wr;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;

  always #5 clk = ~clk;

  cache_mem_responder_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

  cache_mem_responder #(
    .ADDR_W   (ADDR_W),
    .BLOCK_W  (BLOCK_W),
    .DEPTH    (DEPTH),
    .OFFSET_W (OFFSET_W),
    .LATENCY  (LATENCY),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem      (bus.slave),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  exp_t               exp_q[$];
  exp_t               e;
  logic [BLOCK_W-1:0] model_mem [DEPTH];
  logic [BLOCK_W-1:0] model_last;
  int                 model_rd;
  int                 model_wr;
  int                 n_checks = 0;
  int                 n_fail   = 0;
  bit                 in_done  = 1'b0;
  int                 low_cnt  = 0;
  bit                 prev_ready = 1'b1;

  function automatic void check(string name, logic [BLOCK_W-1:0] act, logic [BLOCK_W-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = BLOCK_W'(i);
    model_last = '0;
    model_rd   = 0;
    model_wr   = 0;
    exp_q.delete();
  endfunction

  function automatic logic [BLOCK_W-1:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issue one request, update the model at acceptance, then wiggle inputs
  // while busy; returns at the negedge where DONE is visible.
  task automatic do_req(input logic [ADDR_W-1:0] addr, input logic rw,
                        input logic [BLOCK_W-1:0] data, input int gap);
    int idx;
    int n;
    bus.mem_req_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.mem_req_addr    = addr;
    bus.mem_req_rw      = rw;
    bus.mem_req_dataout = data;
    bus.mem_req_valid   = 1'b1;
    if (in_done && gap == 0) @(negedge clk);
    @(posedge clk);
    idx = int'(addr >> OFFSET_W) % DEPTH;
    if (rw) begin
      model_mem[idx] = data;
      if (model_wr < CNT_MAX) model_wr++;
    end else begin
      model_last = model_mem[idx];
      if (model_rd < CNT_MAX) model_rd++;
    end
    exp_q.push_back('{model_last, model_rd, model_wr});
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.mem_req_ready) break;
      bus.mem_req_addr    = $urandom;
      bus.mem_req_rw      = 1'($urandom);
      bus.mem_req_dataout = rand_block();
      bus.mem_req_valid   = 1'($urandom);
    end
    if (n == 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: ready low for %0d cycles, required %0d", n, LATENCY);
    end
    in_done = 1'b1;
  endtask

  // Completion monitor: a rise of ready after a low stretch marks DONE.
  always @(negedge clk) begin
    if (rst) begin
      low_cnt    = 0;
      prev_ready = 1'b1;
    end else begin
      if (!bus.mem_req_ready) begin
        low_cnt++;
      end else if (!prev_ready) begin
        check("busy_len", BLOCK_W'(low_cnt), BLOCK_W'(LATENCY));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got completion, required none pending");
        end else begin
          e = exp_q.pop_front();
          check("datain",   bus.mem_req_datain, e.data);
          check("rd_count", BLOCK_W'(rd_count), BLOCK_W'(e.rd));
          check("wr_count", BLOCK_W'(wr_count), BLOCK_W'(e.wr));
        end
        low_cnt = 0;
      end
      prev_ready = bus.mem_req_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    rst                 = 1'b1;
    bus.mem_req_addr    = '0;
    bus.mem_req_dataout = '0;
    bus.mem_req_rw      = 1'b0;
    bus.mem_req_valid   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_ready",  BLOCK_W'(bus.mem_req_ready), BLOCK_W'(1));
    check("reset_datain", bus.mem_req_datain, '0);
    check("reset_rd",     BLOCK_W'(rd_count), '0);
    check("reset_wr",     BLOCK_W'(wr_count), '0);
    #2 rst = 1'b0;

    do_req(32'hBB00, 1'b0, rand_block(), 0);
    do_req(32'hAB00, 1'b1, 128'h1122, 1);
    do_req(32'hEB00, 1'b0, rand_block(), 1);

    // Reset during the first BUSY cycle of a write.
    bus.mem_req_valid = 1'b0;
    @(negedge clk);
    bus.mem_req_addr    = 32'h0010;
    bus.mem_req_rw      = 1'b1;
    bus.mem_req_dataout = 128'h5566;
    bus.mem_req_valid   = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    bus.mem_req_valid = 1'b0;
    #1;
    check("midrst_ready",  BLOCK_W'(bus.mem_req_ready), BLOCK_W'(1));
    check("midrst_datain", bus.mem_req_datain, '0);
    check("midrst_wr",     BLOCK_W'(wr_count), '0);
    model_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    in_done = 1'b0;

    do_req(32'h0010, 1'b0, rand_block(), 0);
    do_req(32'h0020, 1'b0, rand_block(), 1);
    do_req(32'h0020, 1'b0, rand_block(), 0);
    do_req(32'h0030, 1'b0, rand_block(), 1);

    for (int k = 0; k < 40; k++) begin
      a      = $urandom;
      a[9:4] = 6'($urandom_range(0, 7));
      do_req(a, 1'($urandom), rand_block(), $urandom_range(0, 2));
    end

    bus.mem_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("queue_drained", BLOCK_W'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
